// File: rtl/uart_fifo_pkg.sv
// Shared types and constants for the UART transmit byte FIFO.
package uart_fifo_pkg;

   localparam int DEFAULT_DEPTH_LOG2 = 4;
   localparam int BYTE_W             = 8;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ACK       = 2'd1,
      WAIT_FREE = 2'd2
   } tx_state_e;

endpackage

// File: rtl/sync_byte_fifo.sv
// Circular byte store with extended pointers, flush and overflow reporting.
module sync_byte_fifo
   import uart_fifo_pkg::*;
#(
   parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2,
   parameter int DATA_W     = BYTE_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic [DATA_W-1:0]     push_data,
   input  logic                  pop,
   input  logic                  flush,
   output logic [DATA_W-1:0]     rd_data,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  overflow
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] PTR_INC  = {{DEPTH_LOG2{1'b0}}, 1'b1};
   localparam logic [DEPTH_LOG2:0] FULL_XOR = {1'b1, {DEPTH_LOG2{1'b0}}};

   logic [DEPTH_LOG2:0] wr_ptr;
   logic [DEPTH_LOG2:0] rd_ptr;
   logic [DATA_W-1:0]   mem [DEPTH];
   logic                do_push;
   logic                do_pop;

   // Pointer MSB is the wrap bit: equal low bits with differing MSB means full.
   assign full    = (wr_ptr ^ rd_ptr) == FULL_XOR;
   assign empty   = (wr_ptr == rd_ptr);
   assign level   = wr_ptr - rd_ptr;
   assign rd_data = mem[rd_ptr[DEPTH_LOG2-1:0]];

   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr[DEPTH_LOG2-1:0]] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_INC;
         end
         if (flush) begin
            rd_ptr <= wr_ptr;
         end else if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_INC;
         end
         // Full is judged before any same-edge pop; flush swallows the write silently.
         overflow <= push && full && !flush;
      end
   end

endmodule

// File: rtl/uart_tx_byte_fifo.sv
// Byte FIFO feeding a UART transmitter, pacing loads on the UART busy flag.
module uart_tx_byte_fifo
   import uart_fifo_pkg::*;
#(
   parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2,
   parameter int DATA_W     = BYTE_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic                  flush,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  overflow,
   output logic                  ena_tx,
   output logic [DATA_W-1:0]     tx_data,
   input  logic                  tx_busy,
   output tx_state_e             fsm_state
);

   tx_state_e         state;
   logic              load;
   logic [DATA_W-1:0] head_data;

   sync_byte_fifo #(
      .DEPTH_LOG2 (DEPTH_LOG2),
      .DATA_W     (DATA_W)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (wr_en),
      .push_data (wr_data),
      .pop       (load),
      .flush     (flush),
      .rd_data   (head_data),
      .full      (full),
      .empty     (empty),
      .level     (level),
      .overflow  (overflow)
   );

   // Load handshake: ena_tx is a one-cycle strobe issued only while tx_busy=0;
   // the UART acknowledges by raising tx_busy, and the next load waits for it to fall.
   assign load      = (state == IDLE) && !empty && !tx_busy && !flush;
   assign fsm_state = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         ena_tx  <= 1'b0;
         tx_data <= '0;
      end else begin
         ena_tx <= load;
         case (state)
            IDLE: begin
               if (load) begin
                  tx_data <= head_data;
                  state   <= ACK;
               end
            end
            ACK: begin
               if (tx_busy) begin
                  state <= WAIT_FREE;
               end
            end
            WAIT_FREE: begin
               if (!tx_busy) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_byte_fifo.sv
// Directed bench for uart_tx_byte_fifo with a behavioural UART busy model.
module tb_uart_tx_byte_fifo;
   import uart_fifo_pkg::*;

   localparam int DL = 4;

   logic        clk     = 1'b0;
   logic        rst_n   = 1'b0;
   logic        wr_en   = 1'b0;
   logic [7:0]  wr_data = 8'h00;
   logic        flush   = 1'b0;
   logic        full;
   logic        empty;
   logic [DL:0] level;
   logic        overflow;
   logic        ena_tx;
   logic [7:0]  tx_data;
   logic        tx_busy;
   tx_state_e   fsm_state;

   logic        model_busy = 1'b0;
   logic        force_busy = 1'b0;
   int          busy_cnt   = 0;
   int          busy_len   = 10;

   int          errors     = 0;
   int          checks     = 0;
   int          pulses     = 0;
   int          ovf_count  = 0;
   int          p0;
   int          o0;
   logic        prev_ena   = 1'b0;
   logic        prev_busy  = 1'b0;
   logic [7:0]  exp_q[$];

   // clock / reset
   always #5 clk = ~clk;

   uart_tx_byte_fifo #(.DEPTH_LOG2(DL), .DATA_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (wr_en),
      .wr_data   (wr_data),
      .flush     (flush),
      .full      (full),
      .empty     (empty),
      .level     (level),
      .overflow  (overflow),
      .ena_tx    (ena_tx),
      .tx_data   (tx_data),
      .tx_busy   (tx_busy),
      .fsm_state (fsm_state)
   );

   // UART model: busy rises one cycle after ena_tx, stays busy_len cycles; ignores rst_n.
   assign tx_busy = model_busy | force_busy;
   always @(posedge clk) begin
      if (ena_tx) begin
         model_busy <= 1'b1;
         busy_cnt   <= busy_len - 1;
      end else if (busy_cnt != 0) begin
         busy_cnt <= busy_cnt - 1;
      end else begin
         model_busy <= 1'b0;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // scoreboard: every load must match the oldest expected byte
   always @(negedge clk) begin
      if (rst_n) begin
         if (ena_tx) begin
            pulses++;
            check("busy_before_load", 32'(prev_busy), 32'd0);
            check("no_back_to_back", 32'(prev_ena), 32'd0);
            checks++;
            assert (exp_q.size() != 0) else begin
               errors++;
               $error("FAIL unexpected_tx: observed %0h expected no load", tx_data);
            end
            if (exp_q.size() != 0) begin
               check("tx_data_order", 32'(tx_data), 32'(exp_q.pop_front()));
            end
         end
         if (overflow) ovf_count++;
      end
      prev_ena  = ena_tx;
      prev_busy = tx_busy;
   end

   // driver tasks
   task automatic write_byte(input logic [7:0] d);
      wr_en   = 1'b1;
      wr_data = d;
      @(posedge clk); #1;
      wr_en   = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (!(exp_q.size() == 0 && empty && !tx_busy && fsm_state == IDLE) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("drain_pending", 32'(exp_q.size()), 32'd0);
      check("drain_in_time", 32'(n < budget), 32'd1);
      @(posedge clk); #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset state
      repeat (2) @(negedge clk);
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_full", 32'(full), 32'd0);
      check("rst_level", 32'(level), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_ena_tx", 32'(ena_tx), 32'd0);
      check("rst_tx_data", 32'(tx_data), 32'd0);
      check("rst_state", 32'(fsm_state), 32'(IDLE));
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // single byte latency
      busy_len = 10;
      p0 = pulses;
      exp_q.push_back(8'hA5);
      write_byte(8'hA5);
      @(negedge clk);
      check("t1_no_early_ena", 32'(ena_tx), 32'd0);
      check("t1_level1", 32'(level), 32'd1);
      @(negedge clk);
      check("t1_ena", 32'(ena_tx), 32'd1);
      check("t1_data", 32'(tx_data), 32'hA5);
      check("t1_empty_after_pop", 32'(empty), 32'd1);
      @(posedge clk); #1;
      wait_idle(200);
      check("t1_one_pulse", 32'(pulses - p0), 32'd1);

      // burst of 16 fills the FIFO, then streams out in order
      busy_len   = 50;
      force_busy = 1'b1;
      for (int i = 0; i < 16; i++) begin
         exp_q.push_back(8'(i));
         wr_en   = 1'b1;
         wr_data = 8'(i);
         @(posedge clk); #1;
         if (i == 14) check("t2_not_full_at_15", 32'(full), 32'd0);
      end
      wr_en = 1'b0;
      check("t2_full", 32'(full), 32'd1);
      check("t2_level16", 32'(level), 32'd16);
      force_busy = 1'b0;
      wait_idle(2000);

      // 17 writes against a busy UART: the last one overflows
      busy_len   = 4;
      force_busy = 1'b1;
      o0 = ovf_count;
      for (int i = 0; i < 17; i++) begin
         if (i < 16) exp_q.push_back(8'(8'h20 + i));
         wr_en   = 1'b1;
         wr_data = 8'(8'h20 + i);
         @(posedge clk); #1;
      end
      wr_en = 1'b0;
      @(negedge clk);
      check("t3_overflow", 32'(overflow), 32'd1);
      check("t3_level16", 32'(level), 32'd16);
      check("t3_full", 32'(full), 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      check("t3_overflow_low", 32'(overflow), 32'd0);
      check("t3_overflow_once", 32'(ovf_count - o0), 32'd1);
      @(posedge clk); #1;
      // write coinciding with a pop while full is still dropped
      force_busy = 1'b0;
      write_byte(8'hEE);
      @(negedge clk);
      check("t3_full_pop_overflow", 32'(overflow), 32'd1);
      check("t3_full_pop_level", 32'(level), 32'd15);
      check("t3_full_pop_ena", 32'(ena_tx), 32'd1);
      @(posedge clk); #1;
      wait_idle(600);

      // simultaneous write and pop at level 3
      force_busy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(8'(8'h40 + i));
         write_byte(8'(8'h40 + i));
      end
      check("t4_level3", 32'(level), 32'd3);
      force_busy = 1'b0;
      exp_q.push_back(8'h43);
      write_byte(8'h43);
      @(negedge clk);
      check("t4_level_kept", 32'(level), 32'd3);
      check("t4_ena", 32'(ena_tx), 32'd1);
      @(posedge clk); #1;
      wait_idle(300);

      // flush during ACK with a write pending
      force_busy = 1'b1;
      exp_q.push_back(8'h50);
      for (int i = 0; i < 6; i++) write_byte(8'(8'h50 + i));
      check("t5_level6", 32'(level), 32'd6);
      p0 = pulses;
      o0 = ovf_count;
      force_busy = 1'b0;
      @(posedge clk); #1;
      check("t5_in_ack", 32'(fsm_state), 32'(ACK));
      check("t5_level5", 32'(level), 32'd5);
      flush   = 1'b1;
      wr_en   = 1'b1;
      wr_data = 8'h99;
      @(posedge clk); #1;
      flush = 1'b0;
      wr_en = 1'b0;
      @(negedge clk);
      check("t5_level0", 32'(level), 32'd0);
      check("t5_empty", 32'(empty), 32'd1);
      check("t5_no_overflow", 32'(overflow), 32'd0);
      check("t5_still_ack", 32'(fsm_state), 32'(ACK));
      @(posedge clk); #1;
      wait_idle(300);
      check("t5_single_load", 32'(pulses - p0), 32'd1);
      check("t5_no_overflow_seen", 32'(ovf_count - o0), 32'd0);

      // asynchronous reset mid-burst
      busy_len   = 20;
      force_busy = 1'b1;
      exp_q.push_back(8'h60);
      for (int i = 0; i < 8; i++) write_byte(8'(8'h60 + i));
      force_busy = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      check("t6_wait_free", 32'(fsm_state), 32'(WAIT_FREE));
      check("t6_level7", 32'(level), 32'd7);
      check("t6_data_loaded", 32'(tx_data), 32'h60);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_rst_level", 32'(level), 32'd0);
      check("t6_rst_empty", 32'(empty), 32'd1);
      check("t6_rst_tx_data", 32'(tx_data), 32'd0);
      check("t6_rst_state", 32'(fsm_state), 32'(IDLE));
      check("t6_rst_ena", 32'(ena_tx), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      p0 = pulses;
      repeat (40) begin
         @(posedge clk); #1;
      end
      check("t6_no_load_after_reset", 32'(pulses - p0), 32'd0);
      exp_q.push_back(8'h77);
      write_byte(8'h77);
      wait_idle(200);
      check("t6_new_write_sent", 32'(pulses - p0), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
